can_bit_timing: RTL

CAN_BIT_TIMING -- requirements
Module: can_bit_timing

---
 rtl/can_bit_timing.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/can_bit_timing.sv
// can_bit_timing
//   CAN bit-timing logic. Synchronises the raw bus level, divides clk into
//   time quanta and walks each bit through SYNC -> SEG1 -> SEG2. It samples
//   the bus at the end of SEG1 and applies hard sync and resynchronisation
//   on recessive-to-dominant edges.
//
// Ports
//   clk          system clock; all logic on its rising edge
//   rst          synchronous reset, active low
//   rx           raw asynchronous bus level (1 = recessive)
//   hard_sync_en high while the bus is idle or in intermission; the next
//                falling edge then hard-syncs
//   brp          prescaler; one tq = brp+1 clk
//   tseg1        SEG1 length = tseg1+1 tq
//   tseg2        SEG2 length = tseg2+1 tq
//   sjw          resync jump width = sjw+1 tq
//   rx_bit       registered sampled bit
//   sample_point one-clk pulse, coincident with each new rx_bit value
//   tx_point     one-clk pulse in the first clk of every bit
//
// Handshake: none. sample_point and tx_point are single-cycle strobes that
// qualify rx_bit and the bit start; there is no back-pressure.
module can_bit_timing (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       hard_sync_en,
  input  logic [5:0] brp,
  input  logic [3:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic [1:0] sjw,
  output logic       rx_bit,
  output logic       sample_point,
  output logic       tx_point
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_SEG1 = 2'd1,
    ST_SEG2 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_prev_q, rx_prev_d;
  logic [5:0]  presc_q, presc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  seg1_end_q, seg1_end_d;
  logic [2:0]  seg2_end_q, seg2_end_d;
  logic [5:0]  brp_l_q, brp_l_d;
  logic [3:0]  tseg1_l_q, tseg1_l_d;
  logic [2:0]  tseg2_l_q, tseg2_l_d;
  logic [1:0]  sjw_l_q, sjw_l_d;
  logic        used_q, used_d;
  logic        first_q, first_d;
  logic        rx_bit_q, rx_bit_d;
  logic        sample_q, sample_d;
  logic        tx_q, tx_d;

  logic        edge_det;
  logic        tq_en;
  logic        resync;
  logic        end_now;
  logic [4:0]  sjw_tq;
  logic [4:0]  inc;
  logic [4:0]  ext;
  logic [4:0]  remaining;
  logic [4:0]  seg1_end_n;
  logic [2:0]  seg2_end_n;
  logic        sample_due;

  assign edge_det   = rx_prev_q & ~rx_s_q;
  assign tq_en      = (presc_q == brp_l_q);
  assign sjw_tq     = {3'b000, sjw_l_q} + 5'd1;
  assign inc        = cnt_q + 5'd1;
  // SEG1 extension cannot exceed the number of tq already spent in SEG1.
  assign ext        = (inc < sjw_tq) ? inc : sjw_tq;
  // tq left in SEG2, counting the current one.
  assign remaining  = {2'b00, seg2_end_q} - cnt_q + 5'd1;
  assign sample_due = tq_en && (state_q == ST_SEG1) && (cnt_q == seg1_end_q);
  assign resync     = edge_det && rx_bit_q && !used_q;

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx;
    rx_s_d     = sync1_q;
    rx_prev_d  = rx_s_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    seg1_end_d = seg1_end_q;
    seg2_end_d = seg2_end_q;
    brp_l_d    = brp_l_q;
    tseg1_l_d  = tseg1_l_q;
    tseg2_l_d  = tseg2_l_q;
    sjw_l_d    = sjw_l_q;
    used_d     = used_q;
    first_d    = 1'b0;
    rx_bit_d   = rx_bit_q;
    sample_d   = 1'b0;
    tx_d       = 1'b0;
    end_now    = 1'b0;
    seg1_end_n = seg1_end_q;
    seg2_end_n = seg2_end_q;

    if (first_q) begin
      // First clk out of reset is the SYNC entry: the SYNC tq starts now.
      tx_d = 1'b1;
    end else if (edge_det && hard_sync_en) begin
      state_d    = ST_SEG1;
      cnt_d      = 5'd0;
      presc_d    = 6'd0;
      brp_l_d    = brp;
      tseg1_l_d  = tseg1;
      tseg2_l_d  = tseg2;
      sjw_l_d    = sjw;
      seg1_end_d = {1'b0, tseg1};
      used_d     = 1'b1;
      tx_d       = 1'b1;
      if (sample_due) begin
        sample_d = 1'b1;
        rx_bit_d = rx_s_q;
      end
    end else begin
      presc_d = tq_en ? 6'd0 : presc_q + 6'd1;
      if (resync) begin
        used_d = 1'b1;
        case (state_q)
          ST_SEG1: seg1_end_n = seg1_end_q + ext;
          ST_SEG2: begin
            if (remaining > sjw_tq) seg2_end_n = seg2_end_q - sjw_tq[2:0];
            else end_now = 1'b1;
          end
          default: ;
        endcase
      end
      seg1_end_d = seg1_end_n;
      seg2_end_d = seg2_end_n;

      if (end_now) begin
        // Edge late in SEG2: this edge is the next bit's sync, so jump
        // straight into SEG1 without a SYNC tq.
        state_d    = ST_SEG1;
        cnt_d      = 5'd0;
        presc_d    = 6'd0;
        seg1_end_d = {1'b0, tseg1_l_q};
        tx_d       = 1'b1;
      end else if (tq_en) begin
        case (state_q)
          ST_SYNC: begin
            state_d    = ST_SEG1;
            cnt_d      = 5'd0;
            seg1_end_d = {1'b0, tseg1_l_q};
          end
          ST_SEG1: begin
            if (cnt_q == seg1_end_n) begin
              state_d    = ST_SEG2;
              cnt_d      = 5'd0;
              seg2_end_d = tseg2_l_q;
              sample_d   = 1'b1;
              rx_bit_d   = rx_s_q;
            end else begin
              cnt_d = inc;
            end
          end
          ST_SEG2: begin
            if (cnt_q == {2'b00, seg2_end_n}) begin
              state_d   = ST_SYNC;
              cnt_d     = 5'd0;
              brp_l_d   = brp;
              tseg1_l_d = tseg1;
              tseg2_l_d = tseg2;
              sjw_l_d   = sjw;
              used_d    = 1'b0;
              tx_d      = 1'b1;
            end else begin
              cnt_d = inc;
            end
          end
          default: state_d = ST_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_SYNC;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      presc_q    <= 6'd0;
      cnt_q      <= 5'd0;
      seg1_end_q <= 5'd0;
      seg2_end_q <= 3'd0;
      // Reset parks the FSM in SYNC, so the configuration is captured here.
      brp_l_q    <= brp;
      tseg1_l_q  <= tseg1;
      tseg2_l_q  <= tseg2;
      sjw_l_q    <= sjw;
      used_q     <= 1'b0;
      first_q    <= 1'b1;
      rx_bit_q   <= 1'b1;
      sample_q   <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      seg1_end_q <= seg1_end_d;
      seg2_end_q <= seg2_end_d;
      brp_l_q    <= brp_l_d;
      tseg1_l_q  <= tseg1_l_d;
      tseg2_l_q  <= tseg2_l_d;
      sjw_l_q    <= sjw_l_d;
      used_q     <= used_d;
      first_q    <= first_d;
      rx_bit_q   <= rx_bit_d;
      sample_q   <= sample_d;
      tx_q       <= tx_d;
    end
  end

  assign rx_bit       = rx_bit_q;
  assign sample_point = sample_q;
  assign tx_point     = tx_q;

endmodule
